multi_channel_scoreboard: RTL and testbench

Next-generation scoreboard for the shared linked-list FIFO (linked_list_fifo).
- Tracks per-channel occupancy for all NUM_FIFOS channels, not one hardwired channel.
- Tags the first value pushed on any channel after start. Counts the entries ahead of it on that channel, then checks data_out on the pop that retires it.
- Flags protocol violations (over/underflow, multi-channel push/pop).
- Sits beside the FIFO in formal and simulation tops; prop_signal is the assertion target.

---
 rtl/multi_channel_scoreboard.sv | 184 ++++++++++++++++++
 tb/tb_multi_channel_scoreboard.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_scoreboard.sv
// multi_channel_scoreboard
//   Scoreboard that sits beside the shared linked-list FIFO. It keeps the
//   occupancy of every logical channel, tags the first value pushed after
//   start, and counts down the entries queued ahead of it on its channel.
//   When the tagged entry is popped, it compares data_out against the tag.
//   Protocol violations are flagged separately. prop_signal is the
//   assertion target: it stays high while no data mismatch has been seen.
//
// Optional build macro: SB_DATA_OUT_REG_EN
//   Define it when the FIFO registers data_out. The comparison and the
//   data_out_vld pulse then happen one cycle after the retiring pop, in an
//   extra CHECK state. Without the macro, data_out is compared in the same
//   cycle as the retiring pop.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   arm tracking (honoured only in IDLE)
//   push         in   [NUM_FIFOS] per-channel push strobes
//   pop          in   [NUM_FIFOS] per-channel pop strobes
//   data_in      in   [WIDTH] push data, shared by all channels
//   data_out     in   [WIDTH] FIFO read data
//   data_out_vld out  data_out is being compared this cycle
//   tracking     out  tagged entry is still queued
//   tracked_ch   out  [CH_WIDTH] channel holding the tag
//   done         out  sticky: tagged entry retired
//   proto_err    out  sticky: protocol violation seen
//   prop_signal  out  high while no data mismatch has been detected
module multi_channel_scoreboard #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int NUM_FIFOS = 2,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1),
   parameter int CH_WIDTH  = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_FIFOS-1:0] push,
   input  logic [NUM_FIFOS-1:0] pop,
   input  logic [WIDTH-1:0]     data_in,
   input  logic [WIDTH-1:0]     data_out,
   output logic                 data_out_vld,
   output logic                 tracking,
   output logic [CH_WIDTH-1:0]  tracked_ch,
   output logic                 done,
   output logic                 proto_err,
   output logic                 prop_signal
);

   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
   localparam logic [NUM_FIFOS-1:0] VecOne  = NUM_FIFOS'(1);

`ifdef SB_DATA_OUT_REG_EN
   typedef enum logic [2:0] {StIdle, StArmed, StTrack, StCheck, StDone} state_t;
`else
   typedef enum logic [1:0] {StIdle, StArmed, StTrack, StDone} state_t;
`endif

   state_t               state_q;
   logic [CNT_WIDTH-1:0] cnt_q [NUM_FIFOS];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_FIFOS];
   logic [CNT_WIDTH-1:0] ahead_q;
   logic [WIDTH-1:0]     tag_q;
   logic [CH_WIDTH-1:0]  tracked_ch_q;
   logic                 done_q;
   logic                 proto_err_q;
   logic                 mismatch_q;

   logic                 bad_occ;
   logic                 multi_push;
   logic                 multi_pop;
   logic [CH_WIDTH-1:0]  cap_ch;
   logic [CNT_WIDTH-1:0] cap_cnt;
   logic [CNT_WIDTH-1:0] cap_ahead;
   logic                 trk_pop;
   logic                 retire;

   // Occupancy next-state; overflow/underflow leave the count unchanged.
   always_comb begin
      bad_occ = 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (push[i] && !pop[i]) begin
            if (cnt_q[i] == CntFull) bad_occ = 1'b1;
            else                     cnt_d[i] = cnt_q[i] + CntOne;
         end else if (pop[i]) begin
            if (cnt_q[i] == '0)      bad_occ = 1'b1;
            else if (!push[i])       cnt_d[i] = cnt_q[i] - CntOne;
         end
      end
   end

   // x & (x-1) is nonzero exactly when more than one bit is set.
   assign multi_push = |(push & (push - VecOne));
   assign multi_pop  = |(pop & (pop - VecOne));

   // Lowest set push bit selects the capture channel.
   always_comb begin
      cap_ch = '0;
      for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
         if (push[i]) cap_ch = CH_WIDTH'(i);
      end
   end

   assign cap_cnt = cnt_q[cap_ch];
   // A same-cycle pop on the capture channel removes one older entry.
   assign cap_ahead = (pop[cap_ch] && cap_cnt != '0) ? cap_cnt - CntOne : cap_cnt;

   assign trk_pop = pop[tracked_ch_q];
   assign retire  = (state_q == StTrack) && trk_pop && (ahead_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         ahead_q      <= '0;
         tag_q        <= '0;
         tracked_ch_q <= '0;
         done_q       <= 1'b0;
         proto_err_q  <= 1'b0;
         mismatch_q   <= 1'b0;
         for (int i = 0; i < NUM_FIFOS; i++) cnt_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (bad_occ || multi_push || multi_pop) proto_err_q <= 1'b1;

         case (state_q)
            StIdle: begin
               if (start) state_q <= StArmed;
            end
            StArmed: begin
               if (|push) begin
                  tag_q        <= data_in;
                  tracked_ch_q <= cap_ch;
                  ahead_q      <= cap_ahead;
                  state_q      <= StTrack;
               end
            end
            StTrack: begin
               if (trk_pop) begin
                  if (ahead_q != '0) begin
                     ahead_q <= ahead_q - CntOne;
                  end else begin
`ifdef SB_DATA_OUT_REG_EN
                     state_q <= StCheck;
`else
                     if (data_out != tag_q) mismatch_q <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= StDone;
`endif
                  end
               end
            end
`ifdef SB_DATA_OUT_REG_EN
            StCheck: begin
               // Registered FIFO read data for the retired entry arrives now.
               if (data_out != tag_q) mismatch_q <= 1'b1;
               done_q  <= 1'b1;
               state_q <= StDone;
            end
`endif
            default: begin
               // StDone is terminal until reset.
            end
         endcase
      end
   end

`ifdef SB_DATA_OUT_REG_EN
   assign data_out_vld = (state_q == StCheck);
   logic unused_retire;
   assign unused_retire = retire;
`else
   assign data_out_vld = retire;
`endif

   assign tracking    = (state_q == StTrack);
   assign tracked_ch  = tracked_ch_q;
   assign done        = done_q;
   assign proto_err   = proto_err_q;
   assign prop_signal = ~mismatch_q;

endmodule

// File: tb/tb_multi_channel_scoreboard.sv
// Testbench for multi_channel_scoreboard (default build: same-cycle compare).
// The reference model keeps real per-channel FIFO contents and remembers the
// position of the tagged entry inside its channel's queue.
module tb_multi_channel_scoreboard;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int NF    = 2;

   logic          clk;
   logic          rst;
   logic          start;
   logic [NF-1:0] push;
   logic [NF-1:0] pop;
   logic [7:0]    data_in;
   logic [7:0]    data_out;
   logic          data_out_vld;
   logic          tracking;
   logic [0:0]    tracked_ch;
   logic          done;
   logic          proto_err;
   logic          prop_signal;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: 0 idle, 1 armed, 2 tracking, 3 done.
   int         m_state;
   logic [7:0] m_tag;
   int         m_ch;
   int         m_pos;
   bit         m_done;
   bit         m_err;
   bit         m_mis;
   logic [7:0] mem [NF][DEPTH];
   int         mcnt [NF];

   multi_channel_scoreboard #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .NUM_FIFOS (NF)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .data_out_vld (data_out_vld),
      .tracking     (tracking),
      .tracked_ch   (tracked_ch),
      .done         (done),
      .proto_err    (proto_err),
      .prop_signal  (prop_signal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0;
      m_tag   = '0;
      m_ch    = 0;
      m_pos   = 0;
      m_done  = 0;
      m_err   = 0;
      m_mis   = 0;
      for (int i = 0; i < NF; i++) mcnt[i] = 0;
   endtask

   task automatic q_push(input int c, input logic [7:0] d);
      mem[c][mcnt[c]] = d;
      mcnt[c]++;
   endtask

   task automatic q_pop(input int c);
      for (int k = 0; k < DEPTH - 1; k++) mem[c][k] = mem[c][k+1];
      mcnt[c]--;
   endtask

   task automatic model_update(input logic st, input logic [NF-1:0] pu, input logic [NF-1:0] po,
                               input logic [7:0] din, input logic [7:0] dout);
      int lo;
      if ($countones(pu) > 1 || $countones(po) > 1) m_err = 1;
      case (m_state)
         0: if (st) m_state = 1;
         1: if (pu != '0) begin
               lo = 0;
               for (int i = NF - 1; i >= 0; i--) if (pu[i]) lo = i;
               m_tag   = din;
               m_ch    = lo;
               m_pos   = mcnt[lo] - ((po[lo] && mcnt[lo] > 0) ? 1 : 0);
               m_state = 2;
            end
         2: if (po[m_ch]) begin
               if (m_pos == 0) begin
                  if (dout !== m_tag) m_mis = 1;
                  m_done  = 1;
                  m_state = 3;
               end else begin
                  m_pos--;
               end
            end
         default: ;
      endcase
      for (int c = 0; c < NF; c++) begin
         if (pu[c] && po[c]) begin
            if (mcnt[c] == 0) m_err = 1;
            else begin
               q_pop(c);
               q_push(c, din);
            end
         end else if (pu[c]) begin
            if (mcnt[c] == DEPTH) m_err = 1;
            else q_push(c, din);
         end else if (po[c]) begin
            if (mcnt[c] == 0) m_err = 1;
            else q_pop(c);
         end
      end
   endtask

   // One clock cycle: drive at negedge, check the combinational compare
   // strobe before the edge, update the model, check registered outputs.
   task automatic step(input logic st, input logic [NF-1:0] pu, input logic [NF-1:0] po,
                       input logic [7:0] din, input logic corrupt);
      int         pc;
      logic [7:0] dout;
      logic       exp_vld;
      @(negedge clk);
      pc = -1;
      if (m_state == 2 && po[m_ch]) pc = m_ch;
      else for (int i = NF - 1; i >= 0; i--) if (po[i]) pc = i;
      dout = (pc >= 0 && mcnt[pc] > 0) ? mem[pc][0] : 8'($urandom);
      if (corrupt) dout = dout ^ 8'h01;
      start    = st;
      push     = pu;
      pop      = po;
      data_in  = din;
      data_out = dout;
      #1;
      exp_vld = (m_state == 2) && po[m_ch] && (m_pos == 0);
      n_cmp++;
      if (data_out_vld !== exp_vld) begin
         n_fail++;
         $display("FAIL data_out_vld: got %b want %b (t=%0t)", data_out_vld, exp_vld, $time);
      end
      @(posedge clk);
      #1;
      model_update(st, pu, po, din, dout);
      start = 1'b0;
      push  = '0;
      pop   = '0;
      n_cmp++;
      if (tracking !== (m_state == 2)) begin
         n_fail++;
         $display("FAIL tracking: got %b want %b (t=%0t)", tracking, (m_state == 2), $time);
      end
      n_cmp++;
      if (tracked_ch !== 1'(m_ch)) begin
         n_fail++;
         $display("FAIL tracked_ch: got %0d want %0d (t=%0t)", tracked_ch, m_ch, $time);
      end
      n_cmp++;
      if (done !== m_done) begin
         n_fail++;
         $display("FAIL done: got %b want %b (t=%0t)", done, m_done, $time);
      end
      n_cmp++;
      if (proto_err !== m_err) begin
         n_fail++;
         $display("FAIL proto_err: got %b want %b (t=%0t)", proto_err, m_err, $time);
      end
      n_cmp++;
      if (prop_signal !== !m_mis) begin
         n_fail++;
         $display("FAIL prop_signal: got %b want %b (t=%0t)", prop_signal, !m_mis, $time);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if ({data_out_vld, tracking, tracked_ch, done, proto_err, prop_signal} !== 6'b000001) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 000001",
                  {data_out_vld, tracking, tracked_ch, done, proto_err, prop_signal});
      end
      @(negedge clk);
      rst = 1'b0;
      idle(2);
   endtask

   // Two entries queued before start, then the tagged push: retires on pop 3.
   task automatic test_basic(input logic corrupt);
      do_reset();
      step(1'b0, 2'b10, 2'b00, 8'h11, 1'b0);
      step(1'b0, 2'b10, 2'b00, 8'h22, 1'b0);
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b10, 2'b00, 8'hA5, 1'b0);
      step(1'b0, 2'b00, 2'b10, 8'h00, 1'b0);
      step(1'b0, 2'b00, 2'b10, 8'h00, 1'b0);
      step(1'b0, 2'b00, 2'b10, 8'h00, corrupt);
      n_cmp++;
      if (done !== 1'b1 || prop_signal !== !corrupt) begin
         n_fail++;
         $display("FAIL basic_retire: got done=%b prop=%b want done=1 prop=%b",
                  done, prop_signal, !corrupt);
      end
      idle(10);
      n_cmp++;
      if (prop_signal !== !corrupt) begin
         n_fail++;
         $display("FAIL prop_sticky: got %b want %b", prop_signal, !corrupt);
      end
   endtask

   task automatic test_cross_channel();
      do_reset();
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b01, 2'b00, 8'h3C, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 2'b00, 8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 2'b10, 8'h00, 1'b0);
      step(1'b0, 2'b00, 2'b01, 8'h00, 1'b0);
      n_cmp++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL cross_done: got %b want 1", done);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(1'b0, 2'b01, 2'b00, 8'h01, 1'b0);
      step(1'b0, 2'b01, 2'b00, 8'h02, 1'b0);
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b01, 2'b01, 8'h77, 1'b0);
      step(1'b0, 2'b00, 2'b01, 8'h00, 1'b0);
      n_cmp++;
      if (done !== 1'b0 || tracking !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_early: got done=%b tracking=%b want done=0 tracking=1",
                  done, tracking);
      end
      step(1'b0, 2'b00, 2'b01, 8'h00, 1'b0);
      n_cmp++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_retire: got %b want 1", done);
      end
   endtask

   task automatic test_proto_errors();
      // Overflow: five pushes leave four entries; push+pop at full then
      // captures with three ahead, so retirement lands on the fourth pop.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 2'b00, 8'(8'h50 + i), 1'b0);
      n_cmp++;
      if (proto_err !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_err: got %b want 1", proto_err);
      end
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b01, 2'b01, 8'hEE, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 2'b01, 8'h00, 1'b0);
      n_cmp++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_cnt_retire: got %b want 1", done);
      end
      // Multi-bit push captures on channel 0.
      do_reset();
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b11, 2'b00, 8'h99, 1'b0);
      n_cmp++;
      if (proto_err !== 1'b1 || tracked_ch !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_push: got err=%b ch=%0d want err=1 ch=0", proto_err, tracked_ch);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b0, 2'b10, 2'b00, 8'h01, 1'b0);
      step(1'b0, 2'b10, 2'b00, 8'h02, 1'b0);
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b10, 2'b00, 8'h03, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if ({tracking, done, prop_signal, proto_err} !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_mid: got %b want 0010", {tracking, done, prop_signal, proto_err});
      end
      @(negedge clk);
      rst = 1'b0;
      // Counts cleared: a fresh tag on ch1 retires on the very first pop.
      step(1'b1, 2'b00, 2'b00, 8'h00, 1'b0);
      step(1'b0, 2'b10, 2'b00, 8'h5A, 1'b0);
      step(1'b0, 2'b00, 2'b10, 8'h00, 1'b0);
      n_cmp++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_restart: got %b want 1", done);
      end
   endtask

   task automatic test_random();
      logic [NF-1:0] pu;
      logic [NF-1:0] po;
      int            r;
      for (int round = 0; round < 8; round++) begin
         do_reset();
         for (int cyc = 0; cyc < 60; cyc++) begin
            r = int'($urandom_range(0, 15));
            pu = '0;
            if (r >= 8 && r < 12) pu = 2'b01;
            else if (r >= 12 && r < 15) pu = 2'b10;
            else if (r == 15 && $urandom_range(0, 3) == 0) pu = 2'b11;
            po = '0;
            for (int c = 0; c < NF; c++) begin
               if (mcnt[c] > 0 && $urandom_range(0, 2) == 0) po[c] = 1'b1;
            end
            if ($urandom_range(0, 40) == 0) po = 2'b11;
            step(($urandom_range(0, 5) == 0), pu, po, 8'($urandom),
                 ($urandom_range(0, 7) == 0));
         end
      end
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      push     = '0;
      pop      = '0;
      data_in  = '0;
      data_out = '0;
      model_reset();
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_cross_channel();
      test_simultaneous();
      test_proto_errors();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
